// File: rtl/wx_vector_loader_if.sv
// Handshake and vector bus between a word source, the w/x loader and the spreader.
// The master side drives words in and consumes x; the slave side is the loader.
interface wx_vector_loader_if #(
  parameter int size      = 3,
  parameter int data_size = 16
);
  logic [data_size-1:0]      in_data;
  logic                      in_valid;
  logic                      in_is_w;
  logic                      in_ready;
  logic                      clear;
  logic [data_size*size-1:0] w;
  logic [data_size*size-1:0] x;
  logic                      set_w;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, in_is_w, clear, out_ready,
    input  in_ready, w, x, set_w, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_is_w, clear, out_ready,
    output in_ready, w, x, set_w, out_valid
  );
endinterface

// File: rtl/wx_vector_loader.sv
// Assembles streamed weight and input words into full w/x vectors for the spreader.
// Only complete vectors are ever published; partial fills live in private buffers.
module wx_vector_loader #(
  parameter int size      = 3,
  parameter int data_size = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  wx_vector_loader_if.slave  bus
);
  localparam int cnt_w = (size > 1) ? $clog2(size) : 1;
  typedef logic [cnt_w-1:0] cnt_t;
  localparam cnt_t last_idx = cnt_t'(size - 1);

  typedef enum logic [1:0] {FILL, WCOMMIT, XVALID} state_t;

  state_t                    state;
  state_t                    state_next;
  cnt_t                      w_cnt;
  cnt_t                      x_cnt;
  logic [data_size*size-1:0] w_buf;
  logic [data_size*size-1:0] x_buf;
  logic [data_size*size-1:0] w_next;
  logic [data_size*size-1:0] x_next;
  logic [data_size*size-1:0] w_vec;
  logic [data_size*size-1:0] x_vec;
  logic                      accept;

  assign accept        = bus.in_valid && (state == FILL);
  assign bus.in_ready  = (state == FILL);
  assign bus.set_w     = (state == WCOMMIT);
  assign bus.out_valid = (state == XVALID);
  assign bus.w         = w_vec;
  assign bus.x         = x_vec;

  // Buffer contents with the incoming word merged in, so a completing word
  // can be published on the same edge it is accepted.
  always_comb begin
    w_next = w_buf;
    x_next = x_buf;
    w_next[int'(w_cnt)*data_size +: data_size] = bus.in_data;
    x_next[int'(x_cnt)*data_size +: data_size] = bus.in_data;
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (accept && bus.in_is_w && (w_cnt == last_idx))
            state_next = WCOMMIT;
          else if (accept && !bus.in_is_w && (x_cnt == last_idx))
            state_next = XVALID;
        end
        WCOMMIT: state_next = FILL;
        XVALID:  if (bus.out_ready) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt <= '0;
      x_cnt <= '0;
      w_buf <= '0;
      x_buf <= '0;
      w_vec <= '0;
      x_vec <= '0;
    end else if (bus.clear) begin
      w_cnt <= '0;
      x_cnt <= '0;
    end else if (accept) begin
      if (bus.in_is_w) begin
        w_buf <= w_next;
        if (w_cnt == last_idx) begin
          w_vec <= w_next;
          w_cnt <= '0;
        end else begin
          w_cnt <= w_cnt + cnt_t'(1);
        end
      end else begin
        x_buf <= x_next;
        if (x_cnt == last_idx) begin
          x_vec <= x_next;
          x_cnt <= '0;
        end else begin
          x_cnt <= x_cnt + cnt_t'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_wx_vector_loader.sv
// Self-checking bench for wx_vector_loader: directed vector table, hand-written
// clear/reset sequences, then random traffic against a queue-based reference model.
module tb_wx_vector_loader;
  localparam int SIZE = 3;
  localparam int DW   = 16;

  typedef logic [DW*SIZE-1:0] vec_w_t;

  typedef struct {
    logic        valid;
    logic        is_w;
    logic [15:0] data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_set_w;
    logic        exp_out_valid;
    vec_w_t      exp_w;
    vec_w_t      exp_x;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wx_vector_loader_if #(.size(SIZE), .data_size(DW)) bus ();

  wx_vector_loader #(.size(SIZE), .data_size(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [98:0] act, input logic [98:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got {rdy,setw,oval,w,x}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic ir, input logic sw, input logic ov,
                             input vec_w_t ew, input vec_w_t ex);
    check_output(name, {bus.in_ready, bus.set_w, bus.out_valid, bus.w, bus.x}, {ir, sw, ov, ew, ex});
  endtask

  task automatic apply_stimulus(input logic valid, input logic is_w, input logic [15:0] data,
                                input logic clr, input logic ordy);
    @(negedge clk);
    bus.in_valid  = valid;
    bus.in_is_w   = is_w;
    bus.in_data   = data;
    bus.clear     = clr;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic iw, input logic [15:0] d, input logic o,
                              input logic ir, input logic sw, input logic ov,
                              input vec_w_t ew, input vec_w_t ex);
    vec_t r;
    r.valid = v; r.is_w = iw; r.data = d; r.out_ready = o;
    r.exp_in_ready = ir; r.exp_set_w = sw; r.exp_out_valid = ov;
    r.exp_w = ew; r.exp_x = ex;
    return r;
  endfunction

  function automatic vec_w_t pack(input logic [15:0] q[$]);
    vec_w_t r = '0;
    for (int k = 0; k < q.size(); k++) r[k*DW +: DW] = q[k];
    return r;
  endfunction

  initial begin
    vec_t   vecs[$];
    vec_w_t w1 = 48'h0003_0002_0001;
    vec_w_t x1 = 48'h000C_000B_000A;
    vec_w_t w2 = 48'h0103_0102_0101;
    vec_w_t x2 = 48'h0A03_0A02_0A01;
    vec_w_t w3 = 48'h0012_0011_0010;
    vec_w_t x3 = 48'h0003_0002_0001;
    vec_w_t w4 = 48'h0009_0008_0007;
    vec_w_t x4 = 48'h0033_0032_0031;
    logic [15:0] mw[$];
    logic [15:0] mx[$];
    bit     m_commit, m_held;
    vec_w_t m_w, m_x;

    bus.in_valid = 1'b0; bus.in_is_w = 1'b0; bus.in_data = '0;
    bus.clear = 1'b0; bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset_state", 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(1, 1, 16'h0001, 0, 1, 0, 0, '0, '0));
    vecs.push_back(mk(1, 1, 16'h0002, 0, 1, 0, 0, '0, '0));
    vecs.push_back(mk(1, 1, 16'h0003, 0, 0, 1, 0, w1, '0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, w1, '0));
    vecs.push_back(mk(1, 0, 16'h000A, 0, 1, 0, 0, w1, '0));
    vecs.push_back(mk(1, 0, 16'h000B, 0, 1, 0, 0, w1, '0));
    vecs.push_back(mk(1, 0, 16'h000C, 0, 0, 0, 1, w1, x1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, w1, x1));
    vecs.push_back(mk(1, 0, 16'hDEAD, 0, 0, 0, 1, w1, x1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, w1, x1));
    vecs.push_back(mk(1, 1, 16'h0101, 0, 1, 0, 0, w1, x1));
    vecs.push_back(mk(1, 0, 16'h0A01, 0, 1, 0, 0, w1, x1));
    vecs.push_back(mk(1, 1, 16'h0102, 0, 1, 0, 0, w1, x1));
    vecs.push_back(mk(1, 0, 16'h0A02, 0, 1, 0, 0, w1, x1));
    vecs.push_back(mk(1, 1, 16'h0103, 0, 0, 1, 0, w2, x1));
    vecs.push_back(mk(1, 0, 16'hBEEF, 0, 1, 0, 0, w2, x1));
    vecs.push_back(mk(1, 0, 16'h0A03, 0, 0, 0, 1, w2, x2));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, w2, x2));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].valid, vecs[i].is_w, vecs[i].data, 1'b0, vecs[i].out_ready);
      check_state($sformatf("table_%0d", i), vecs[i].exp_in_ready, vecs[i].exp_set_w,
                  vecs[i].exp_out_valid, vecs[i].exp_w, vecs[i].exp_x);
    end

    // clear discards two pending w words and wins over a simultaneous word
    apply_stimulus(1, 1, 16'h0020, 0, 0);
    apply_stimulus(1, 1, 16'h0021, 0, 0);
    apply_stimulus(1, 1, 16'h0099, 1, 0);
    check_state("clear_with_word", 1, 0, 0, w2, x2);
    apply_stimulus(1, 1, 16'h0010, 0, 0);
    apply_stimulus(1, 1, 16'h0011, 0, 0);
    check_state("clear_no_early_setw", 1, 0, 0, w2, x2);
    apply_stimulus(1, 1, 16'h0012, 0, 0);
    check_state("clear_refill_setw", 0, 1, 0, w3, x2);
    apply_stimulus(0, 0, 16'h0000, 0, 0);
    check_state("clear_single_setw", 1, 0, 0, w3, x2);

    apply_stimulus(1, 0, 16'h0001, 0, 0);
    apply_stimulus(1, 0, 16'h0002, 0, 0);
    apply_stimulus(1, 0, 16'h0003, 0, 0);
    check_state("xvalid_before_clear", 0, 0, 1, w3, x3);
    apply_stimulus(0, 0, 16'h0000, 1, 0);
    check_state("clear_in_xvalid", 1, 0, 0, w3, x3);

    apply_stimulus(1, 1, 16'h0007, 0, 0);
    apply_stimulus(1, 1, 16'h0008, 0, 0);
    apply_stimulus(1, 1, 16'h0009, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0);
    check_state("clear_in_wcommit", 1, 0, 0, w4, x3);
    apply_stimulus(0, 0, 16'h0000, 0, 0);
    check_state("clear_wcommit_no_repeat", 1, 0, 0, w4, x3);

    apply_stimulus(1, 0, 16'h0055, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0);
    apply_stimulus(1, 0, 16'h0031, 0, 0);
    apply_stimulus(1, 0, 16'h0032, 0, 0);
    check_state("clear_x_partial", 1, 0, 0, w4, x3);
    apply_stimulus(1, 0, 16'h0033, 0, 0);
    check_state("clear_x_refill", 0, 0, 1, w4, x4);
    apply_stimulus(0, 0, 16'h0000, 1, 0);

    // async reset while x is held
    apply_stimulus(1, 0, 16'h000A, 0, 0);
    apply_stimulus(1, 0, 16'h000B, 0, 0);
    apply_stimulus(1, 0, 16'h000C, 0, 0);
    check_state("pre_reset_xvalid", 0, 0, 1, w4, x1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_reset_xvalid", 1, 0, 0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 1, 16'h0001, 0, 0);
    apply_stimulus(1, 0, 16'h0002, 0, 0);
    apply_stimulus(0, 0, 16'h0000, 1, 0);
    check_state("post_reset_quiet", 1, 0, 0, '0, '0);

    // random traffic against the reference model
    do_reset();
    mw.delete(); mx.delete();
    m_commit = 0; m_held = 0; m_w = '0; m_x = '0;
    for (int c = 0; c < 400; c++) begin
      logic v, iw, clr, ordy;
      logic [15:0] d;
      v    = ($urandom_range(0, 9) < 7);
      iw   = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 29) == 0);
      ordy = ($urandom_range(0, 9) < 4);
      d    = 16'($urandom);
      if (clr) begin
        mw.delete(); mx.delete();
        m_commit = 0; m_held = 0;
      end else if (m_commit) begin
        m_commit = 0;
      end else if (m_held) begin
        if (ordy) m_held = 0;
      end else if (v) begin
        if (iw) begin
          mw.push_back(d);
          if (mw.size() == SIZE) begin
            m_w = pack(mw); mw.delete(); m_commit = 1;
          end
        end else begin
          mx.push_back(d);
          if (mx.size() == SIZE) begin
            m_x = pack(mx); mx.delete(); m_held = 1;
          end
        end
      end
      apply_stimulus(v, iw, d, clr, ordy);
      check_state($sformatf("random_%0d", c), !m_commit && !m_held, m_commit, m_held, m_w, m_x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wx_vector_loader.md
WX_VECTOR_LOADER -- requirements
Module: wx_vector_loader

Interface
REQ-001 Parameter: size, default 3, number of elements per w/x vector.
REQ-002 Parameter: data_size, default 16, bits per element.
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_data  input  data_size  one element word.
REQ-006 Port: in_valid  input  1  in_data/in_is_w valid this cycle.
REQ-007 Port: in_is_w  input  1  1 = word is a weight element, 0 = input (x) element.
REQ-008 Port: in_ready  output  1  loader accepts a word this cycle; a word is accepted when in_valid && in_ready.
REQ-009 Port: clear  input  1  synchronous discard of partially filled vectors.
REQ-010 Port: w  output  data_size*size  committed weight vector, feeds the w/x spreader w input.
REQ-011 Port: x  output  data_size*size  completed input vector, feeds the spreader x input.
REQ-012 Port: set_w  output  1  one-cycle weight-load strobe, feeds the spreader set_w input.
REQ-013 Port: out_valid  output  1  x holds a completed vector awaiting consumption.
REQ-014 Port: out_ready  input  1  downstream consumes x this cycle when out_valid && out_ready.

Function
REQ-015 The FSM SHALL have exactly three states: FILL, WCOMMIT, XVALID.
REQ-016 in_ready SHALL be 1 in FILL and 0 in WCOMMIT/XVALID, decoded from state only (no combinational path from in_valid, in_is_w or out_ready).
REQ-017 Independent counters w_cnt, x_cnt (range 0..size-1) SHALL index w_buf/x_buf; element k occupies bits [k*data_size +: data_size].
REQ-018 In FILL, an accepted word with in_is_w=1 SHALL write w_buf[w_cnt] and increment w_cnt; with in_is_w=0, x_buf[x_cnt] and x_cnt.
REQ-019 Accepting the w word at w_cnt=size-1 SHALL, on that edge, load w with the full vector including that word, reset w_cnt to 0, and move to WCOMMIT.
REQ-020 Accepting the x word at x_cnt=size-1 SHALL, on that edge, load x with the full vector including that word, reset x_cnt to 0, and move to XVALID.
REQ-021 WCOMMIT SHALL last exactly one cycle with set_w=1, then return to FILL; set_w SHALL be 0 in all other states.
REQ-022 XVALID SHALL hold out_valid=1 and x stable until out_ready=1, then return to FILL on that edge.
REQ-023 w SHALL change only on REQ-019 edges; partial fills SHALL never be visible on w or x.
REQ-024 Latency: set_w and out_valid SHALL assert in the cycle immediately following acceptance of the completing word.
REQ-025 Cycles with in_valid=0 SHALL not change counters or buffers.
REQ-026 clear=1 SHALL, on the edge, zero w_cnt and x_cnt and force state to FILL, taking priority over word acceptance and out_ready; w and x SHALL keep their values.
REQ-027 clear asserted in XVALID SHALL drop out_valid the next cycle; clear in WCOMMIT SHALL not extend or repeat set_w.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state FILL, w_cnt=x_cnt=0, w=0, x=0, w_buf=x_buf=0, set_w=0, out_valid=0; in_ready SHALL then read 1.
REQ-029 Reset asserted mid-fill, in WCOMMIT or in XVALID SHALL discard all partial and pending data with no set_w or out_valid after release.

Verification (size=3, data_size=16)
REQ-030 w words 0x0001,0x0002,0x0003 back-to-back -> next cycle set_w=1 for exactly one cycle, w=0x0003_0002_0001, in_ready=0 that cycle only.
REQ-031 x words 0x000A,0x000B,0x000C with out_ready=0 for 5 cycles -> out_valid=1, x=0x000C_000B_000A, in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-032 Interleaved w1,x1,w2,x2,w3 then x3 -> set_w after w3, w=w3_w2_w1; out_valid after x3, x=x3_x2_x1; counters independent.
REQ-033 Two w words, clear pulse, then w 0x0010,0x0011,0x0012 -> single set_w, w=0x0012_0011_0010, earlier words absent.
REQ-034 Random in_valid bubbles during x fill -> identical x result and one out_valid, only accepted words counted.
REQ-035 rst_n pulsed low during XVALID with x=0x000C_000B_000A -> immediately out_valid=0, x=0, w=0; after release in_ready=1, no set_w/out_valid until new full vectors.
